// File: rtl/temp_sequencer_pkg.sv
// Shared one-wire definitions: the command codes understood by the one-wire
// controller, used by both the sequencer and the controller itself.
`timescale 1ns/1ps
package temp_sequencer_pkg;

    localparam int CMD_W = 6;

    typedef enum logic [CMD_W-1:0] {
        OW_IDLE         = 6'd0,
        OW_RESET_DETECT = 6'd1,
        OW_SKIP_ROM     = 6'd2,
        OW_CONVERT_T    = 6'd3,
        OW_READ_SCRATCH = 6'd4,
        OW_NEXT_BYTE    = 6'd5
    } ow_cmd_t;

endpackage

// File: rtl/temp_sequencer_ow_cmd_issue.sv
// One command handshake with the one-wire controller: a single strobe, one guard
// cycle while the controller raises busy, then wait for busy to fall.
`timescale 1ns/1ps
module ow_cmd_issue
    import temp_sequencer_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    input  logic [CMD_W-1:0] i_code,
    input  logic             i_ow_busy,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_cmd_en,
    output logic             o_done
);

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_GUARD,
        PH_WAIT
    } phase_t;

    phase_t phase;
    phase_t phase_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase <= PH_ISSUE;
        end else begin
            phase <= phase_next;
        end
    end

    // Dropping i_go parks the handshake so the next command state strobes at once.
    always_comb begin
        phase_next = phase;
        o_cmd      = OW_IDLE;
        o_cmd_en   = 1'b0;
        o_done     = 1'b0;
        if (!i_go) begin
            phase_next = PH_ISSUE;
        end else begin
            case (phase)
                PH_ISSUE: begin
                    o_cmd      = i_code;
                    o_cmd_en   = 1'b1;
                    phase_next = PH_GUARD;
                end
                PH_GUARD: phase_next = PH_WAIT;
                PH_WAIT: begin
                    if (!i_ow_busy) begin
                        o_done     = 1'b1;
                        phase_next = PH_ISSUE;
                    end
                end
                default: phase_next = PH_ISSUE;
            endcase
        end
    end

endmodule

// File: rtl/temp_sequencer.sv
// Temperature read sequencer: reset/skip/convert, wait for conversion, then
// reset/skip/read-scratchpad and collect the two temperature bytes.
`timescale 1ns/1ps
module temp_sequencer
    import temp_sequencer_pkg::*;
#(
    parameter int CONV_CYCLES = 36_000_000,
    parameter int CW          = 26
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_cmd_en,
    input  logic             i_ow_busy,
    input  logic             i_ow_detect,
    input  logic [7:0]       i_ow_data,
    output logic             o_busy,
    output logic [15:0]      o_temp,
    output logic             o_valid,
    output logic             o_no_dev
);

    localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST1,
        S_SKIP1,
        S_CONV,
        S_WAITC,
        S_RST2,
        S_SKIP2,
        S_RDSCR,
        S_BYTE0,
        S_BYTE1,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          cmd_go;
    ow_cmd_t       cmd_code;
    logic          cmd_done;
    logic [CW-1:0] count;
    logic [7:0]    lsb;
    logic [15:0]   temp;
    logic          no_dev;

    ow_cmd_issue u_issue (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_go      (cmd_go),
        .i_code    (cmd_code),
        .i_ow_busy (i_ow_busy),
        .o_cmd     (o_cmd),
        .o_cmd_en  (o_cmd_en),
        .o_done    (cmd_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_go     = 1'b0;
        cmd_code   = OW_IDLE;
        case (state)
            S_IDLE:  if (i_start) state_next = S_RST1;
            S_RST1: begin
                cmd_go   = 1'b1;
                cmd_code = OW_RESET_DETECT;
                if (cmd_done) state_next = i_ow_detect ? S_SKIP1 : S_IDLE;
            end
            S_SKIP1: begin
                cmd_go   = 1'b1;
                cmd_code = OW_SKIP_ROM;
                if (cmd_done) state_next = S_CONV;
            end
            S_CONV: begin
                cmd_go   = 1'b1;
                cmd_code = OW_CONVERT_T;
                if (cmd_done) state_next = S_WAITC;
            end
            S_WAITC: if (count == '0) state_next = S_RST2;
            S_RST2: begin
                cmd_go   = 1'b1;
                cmd_code = OW_RESET_DETECT;
                if (cmd_done) state_next = i_ow_detect ? S_SKIP2 : S_IDLE;
            end
            S_SKIP2: begin
                cmd_go   = 1'b1;
                cmd_code = OW_SKIP_ROM;
                if (cmd_done) state_next = S_RDSCR;
            end
            S_RDSCR: begin
                cmd_go   = 1'b1;
                cmd_code = OW_READ_SCRATCH;
                if (cmd_done) state_next = S_BYTE0;
            end
            S_BYTE0: begin
                cmd_go   = 1'b1;
                cmd_code = OW_NEXT_BYTE;
                if (cmd_done) state_next = S_BYTE1;
            end
            S_BYTE1: begin
                cmd_go   = 1'b1;
                cmd_code = OW_NEXT_BYTE;
                if (cmd_done) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The conversion counter is loaded as CONVERT_T completes and only counts down while nonzero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count  <= '0;
            lsb    <= '0;
            temp   <= '0;
            no_dev <= 1'b0;
        end else begin
            if (state == S_CONV && cmd_done) begin
                count <= CONV_LOAD;
            end else if (state == S_WAITC && count != '0) begin
                count <= count - CW'(1);
            end
            if ((state == S_RST1 || state == S_RST2) && cmd_done) begin
                no_dev <= !i_ow_detect;
            end
            if (state == S_BYTE0 && cmd_done) begin
                lsb <= i_ow_data;
            end
            if (state == S_BYTE1 && cmd_done) begin
                temp <= {i_ow_data, lsb};
            end
        end
    end

    assign o_busy   = (state != S_IDLE);
    assign o_valid  = (state == S_DONE);
    assign o_temp   = temp;
    assign o_no_dev = no_dev;

endmodule

// File: tb/tb_temp_sequencer.sv
// Directed bench for temp_sequencer against a small one-wire controller model
// that holds busy for a fixed time after each strobe.
`timescale 1ns/1ps
module tb_temp_sequencer;

    localparam int CONV = 10;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [5:0]  o_cmd;
    logic        o_cmd_en;
    logic        i_ow_busy;
    logic        i_ow_detect = 1'b1;
    logic [7:0]  i_ow_data = 8'h00;
    logic        o_busy;
    logic [15:0] o_temp;
    logic        o_valid;
    logic        o_no_dev;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int cycle = 0;
    int valid_cnt = 0;
    int det_q[$];
    int data_q[$];
    int strobe_code[$];
    int strobe_cyc[$];

    temp_sequencer #(.CONV_CYCLES(CONV), .CW(8)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .o_cmd       (o_cmd),
        .o_cmd_en    (o_cmd_en),
        .i_ow_busy   (i_ow_busy),
        .i_ow_detect (i_ow_detect),
        .i_ow_data   (i_ow_data),
        .o_busy      (o_busy),
        .o_temp      (o_temp),
        .o_valid     (o_valid),
        .o_no_dev    (o_no_dev)
    );

    always #5 i_clk = ~i_clk;

    assign i_ow_busy = (busy_cnt != 0);

    // Controller model and strobe logger: each strobe makes the controller busy
    // and presents the next queued presence bit or data byte.
    always @(negedge i_clk) begin
        int v;
        cycle++;
        if (o_valid) valid_cnt++;
        if (o_cmd_en) begin
            strobe_code.push_back(int'(o_cmd));
            strobe_cyc.push_back(cycle);
            busy_cnt = 5;
            if (o_cmd == 6'd1) begin
                v = (det_q.size() > 0) ? det_q.pop_front() : 1;
                i_ow_detect = (v != 0);
            end
            if (o_cmd == 6'd5) begin
                v = (data_q.size() > 0) ? data_q.pop_front() : 0;
                i_ow_data = 8'(v);
            end
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    end

    task automatic clear_logs();
        strobe_code.delete();
        strobe_cyc.delete();
        det_q.delete();
        data_q.delete();
        valid_cnt = 0;
    endtask

    task automatic start_read();
        @(negedge i_clk) i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_timeout: o_busy=%b required 0", name, o_busy);
        end
        @(negedge i_clk);
    endtask

    task automatic wait_strobes(input int count, input string name);
        int n = 0;
        while (strobe_code.size() < count && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (strobe_code.size() < count) begin
            failures++;
            $display("[TB] FAIL %s_strobe_wait: strobes=%0d required %0d", name, strobe_code.size(), count);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_start = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        checks++; if (o_cmd !== 6'd0) begin failures++; $display("[TB] FAIL rst_cmd: got %0d required 0", o_cmd); end
        checks++; if (o_cmd_en !== 1'b0) begin failures++; $display("[TB] FAIL rst_cmd_en: got %b required 0", o_cmd_en); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b required 0", o_busy); end
        checks++; if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b required 0", o_valid); end
        checks++; if (o_temp !== 16'h0000) begin failures++; $display("[TB] FAIL rst_temp: got %h required 0000", o_temp); end
        checks++; if (o_no_dev !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_dev: got %b required 0", o_no_dev); end
    endtask

    task automatic test_full_read();
        int exp_codes[8] = '{1, 2, 3, 1, 2, 4, 5, 5};
        int code;
        int gap;
        clear_logs();
        det_q = '{1, 1};
        data_q = '{8'h91, 8'h01};
        start_read();
        wait_idle("full");
        checks++; if (strobe_code.size() != 8) begin failures++; $display("[TB] FAIL full_strobes: got %0d required 8", strobe_code.size()); end
        for (int i = 0; i < 8; i++) begin
            code = (i < strobe_code.size()) ? strobe_code[i] : -1;
            checks++;
            if (code != exp_codes[i]) begin
                failures++;
                $display("[TB] FAIL full_code%0d: got %0d required %0d", i, code, exp_codes[i]);
            end
        end
        gap = (strobe_cyc.size() >= 4) ? strobe_cyc[3] - strobe_cyc[2] : -1;
        checks++; if (gap != CONV + 6) begin failures++; $display("[TB] FAIL full_conv_gap: got %0d required %0d", gap, CONV + 6); end
        gap = (strobe_cyc.size() >= 2) ? strobe_cyc[1] - strobe_cyc[0] : -1;
        checks++; if (gap != 6) begin failures++; $display("[TB] FAIL full_cmd_gap: got %0d required 6", gap); end
        checks++; if (o_temp !== 16'h0191) begin failures++; $display("[TB] FAIL full_temp: got %h required 0191", o_temp); end
        checks++; if (valid_cnt != 1) begin failures++; $display("[TB] FAIL full_valid: got %0d required 1", valid_cnt); end
        checks++; if (o_no_dev !== 1'b0) begin failures++; $display("[TB] FAIL full_no_dev: got %b required 0", o_no_dev); end
    endtask

    task automatic test_no_dev_rst1();
        clear_logs();
        det_q = '{0};
        start_read();
        wait_idle("nodev1");
        checks++; if (strobe_code.size() != 1) begin failures++; $display("[TB] FAIL nodev1_strobes: got %0d required 1", strobe_code.size()); end
        checks++; if (o_no_dev !== 1'b1) begin failures++; $display("[TB] FAIL nodev1_flag: got %b required 1", o_no_dev); end
        checks++; if (valid_cnt != 0) begin failures++; $display("[TB] FAIL nodev1_valid: got %0d required 0", valid_cnt); end
        checks++; if (o_temp !== 16'h0191) begin failures++; $display("[TB] FAIL nodev1_temp: got %h required 0191", o_temp); end
    endtask

    task automatic test_no_dev_rst2();
        int reads = 0;
        clear_logs();
        det_q = '{1, 0};
        start_read();
        wait_idle("nodev2");
        foreach (strobe_code[i]) if (strobe_code[i] >= 4) reads++;
        checks++; if (strobe_code.size() != 4) begin failures++; $display("[TB] FAIL nodev2_strobes: got %0d required 4", strobe_code.size()); end
        checks++; if (reads != 0) begin failures++; $display("[TB] FAIL nodev2_read_strobes: got %0d required 0", reads); end
        checks++; if (o_no_dev !== 1'b1) begin failures++; $display("[TB] FAIL nodev2_flag: got %b required 1", o_no_dev); end
        checks++; if (valid_cnt != 0) begin failures++; $display("[TB] FAIL nodev2_valid: got %0d required 0", valid_cnt); end
    endtask

    task automatic test_start_ignored();
        int n = 0;
        clear_logs();
        det_q = '{1, 1};
        data_q = '{8'h34, 8'h12};
        start_read();
        wait_strobes(3, "ignore");
        repeat (7) @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        while (!o_valid && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        i_start = 1'b1;
        @(negedge i_clk) i_start = 1'b0;
        repeat (20) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL ignore_busy: got %b required 0", o_busy); end
        checks++; if (valid_cnt != 1) begin failures++; $display("[TB] FAIL ignore_valid: got %0d required 1", valid_cnt); end
        checks++; if (strobe_code.size() != 8) begin failures++; $display("[TB] FAIL ignore_strobes: got %0d required 8", strobe_code.size()); end
        checks++; if (o_temp !== 16'h1234) begin failures++; $display("[TB] FAIL ignore_temp: got %h required 1234", o_temp); end
        checks++; if (o_no_dev !== 1'b0) begin failures++; $display("[TB] FAIL ignore_no_dev: got %b required 0", o_no_dev); end
    endtask

    task automatic test_reset_mid_wait();
        clear_logs();
        det_q = '{1, 1};
        start_read();
        wait_strobes(3, "rstwait");
        repeat (7) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk) i_rst = 1'b0;
        checks++; if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_busy: got %b required 0", o_busy); end
        checks++; if (o_cmd_en !== 1'b0 || o_cmd !== 6'd0) begin failures++; $display("[TB] FAIL rstwait_cmd: got en=%b cmd=%0d required 0/0", o_cmd_en, o_cmd); end
        checks++; if (o_temp !== 16'h0000) begin failures++; $display("[TB] FAIL rstwait_temp: got %h required 0000", o_temp); end
        checks++; if (o_valid !== 1'b0 || o_no_dev !== 1'b0) begin failures++; $display("[TB] FAIL rstwait_flags: got valid=%b no_dev=%b required 0/0", o_valid, o_no_dev); end
        repeat (10) @(negedge i_clk);
        clear_logs();
        det_q = '{1, 1};
        data_q = '{8'h22, 8'h01};
        start_read();
        wait_idle("rstwait_rerun");
        checks++; if (strobe_code.size() != 8) begin failures++; $display("[TB] FAIL rstwait_rerun_strobes: got %0d required 8", strobe_code.size()); end
        checks++; if (o_temp !== 16'h0122) begin failures++; $display("[TB] FAIL rstwait_rerun_temp: got %h required 0122", o_temp); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        det_q = '{1, 1, 1, 1};
        data_q = '{8'h5E, 8'hFF, 8'h50, 8'h05};
        start_read();
        wait_idle("b2b_first");
        checks++; if (o_temp !== 16'hFF5E) begin failures++; $display("[TB] FAIL b2b_first_temp: got %h required ff5e", o_temp); end
        start_read();
        wait_idle("b2b_second");
        checks++; if (o_temp !== 16'h0550) begin failures++; $display("[TB] FAIL b2b_second_temp: got %h required 0550", o_temp); end
        checks++; if (valid_cnt != 2) begin failures++; $display("[TB] FAIL b2b_valid: got %0d required 2", valid_cnt); end
        checks++; if (strobe_code.size() != 16) begin failures++; $display("[TB] FAIL b2b_strobes: got %0d required 16", strobe_code.size()); end
    endtask

    initial begin
        test_reset();
        test_full_read();
        test_no_dev_rst1();
        test_no_dev_rst2();
        test_start_ignored();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
